// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prog_counter
//  Description : Programmable counter with runtime modulus, up/down direction,
//                synchronous load/clear, wrap or saturate at terminal, enable
//                prescaler, terminal-count pulse and sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_counter #(
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int RST_VALUE = 0
) (
    input  logic             FPGA_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             at_term,
    output logic             overflow
);

    // Prescaler needs at least one bit even when it never leaves zero.
    localparam int               c_ps_w      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_ps_w-1:0] c_ps_last  = c_ps_w'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  c_rst_value = WIDTH'(RST_VALUE);

    logic [c_ps_w-1:0] r_pre;
    logic [WIDTH-1:0]  r_count;
    logic              r_tick;
    logic              r_tc;
    logic              r_overflow;

    logic              w_expire;
    logic              w_term;
    logic [WIDTH-1:0]  w_next_count;

    // Step decision and next count value; limit/direction/mode sampled live.
    always_comb begin
        w_expire     = enable && (r_pre == c_ps_last);
        w_term       = 1'b0;
        w_next_count = r_count;
        if (up_down) begin
            // ">=" so an out-of-range loaded value is pulled back on the next step.
            w_term = (r_count >= limit);
            if (w_term) begin
                w_next_count = sat_mode ? limit : '0;
            end else begin
                w_next_count = r_count + 1'b1;
            end
        end else begin
            w_term = (r_count == '0);
            if (w_term) begin
                w_next_count = sat_mode ? '0 : limit;
            end else begin
                w_next_count = r_count - 1'b1;
            end
        end
    end

    // Prescaler, count and flag registers with rst > clear > load > step priority.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            r_pre      <= '0;
            r_count    <= c_rst_value;
            r_tick     <= 1'b0;
            r_tc       <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_pre      <= '0;
            r_count    <= c_rst_value;
            r_tick     <= 1'b0;
            r_tc       <= 1'b0;
            r_overflow <= 1'b0;
        end else if (load) begin
            r_pre      <= '0;
            r_count    <= load_value;
            r_tick     <= 1'b0;
            r_tc       <= 1'b0;
        end else begin
            r_tick <= w_expire;
            r_tc   <= w_expire && w_term;
            if (w_expire) begin
                r_pre   <= '0;
                r_count <= w_next_count;
                if (w_term) begin
                    r_overflow <= 1'b1;
                end
            end else if (enable) begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign tick     = r_tick;
    assign tc       = r_tc;
    assign overflow = r_overflow;
    assign at_term  = (up_down && (r_count == limit)) || (!up_down && (r_count == '0));

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_counter
//  Description : Self-checking bench for prog_counter. Instance A uses
//                PRESCALE=1, instance B uses PRESCALE=4; both share inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_counter;

    logic       FPGA_clk = 1'b0;
    logic       rst, enable, clear, load, up_down, sat_mode;
    logic [7:0] load_value, limit;

    logic [7:0] count_a, count_b;
    logic       tick_a, tc_a, at_a, ovf_a;
    logic       tick_b, tc_b, at_b, ovf_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 FPGA_clk = ~FPGA_clk;

    prog_counter #(.WIDTH(8), .PRESCALE(1), .RST_VALUE(0)) dut_a (
        .FPGA_clk(FPGA_clk), .rst(rst), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .up_down(up_down), .limit(limit),
        .sat_mode(sat_mode), .count(count_a), .tick(tick_a), .tc(tc_a),
        .at_term(at_a), .overflow(ovf_a)
    );

    prog_counter #(.WIDTH(8), .PRESCALE(4), .RST_VALUE(0)) dut_b (
        .FPGA_clk(FPGA_clk), .rst(rst), .enable(enable), .clear(clear),
        .load(load), .load_value(load_value), .up_down(up_down), .limit(limit),
        .sat_mode(sat_mode), .count(count_b), .tick(tick_b), .tc(tc_b),
        .at_term(at_b), .overflow(ovf_b)
    );

    typedef struct {
        logic       r, c, l;
        logic [7:0] lv;
        logic       ud;
        logic [7:0] lim;
        logic       s, e;
        logic [7:0] ecnt;
        logic       etick, etc, eovf;
    } vec_t;

    typedef struct {
        bit         sel;
        int         id;
        logic [7:0] cnt;
        logic       tick, tc, ovf, at;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic c, logic l, logic [7:0] lv, logic ud,
                                logic [7:0] lim, logic s, logic e, logic [7:0] ecnt,
                                logic etick, logic etc, logic eovf);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.lv = lv; v.ud = ud; v.lim = lim; v.s = s; v.e = e;
        v.ecnt = ecnt; v.etick = etick; v.etc = etc; v.eovf = eovf;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
    task automatic cyc(input bit sel, input int id, input vec_t v);
        exp_t e, g;
        logic [7:0] acnt;
        logic       atick, atc, aovf, aat;
        rst = v.r; clear = v.c; load = v.l; load_value = v.lv; up_down = v.ud;
        limit = v.lim; sat_mode = v.s; enable = v.e;
        e.sel = sel; e.id = id; e.cnt = v.ecnt; e.tick = v.etick; e.tc = v.etc; e.ovf = v.eovf;
        e.at  = v.ud ? (v.ecnt == v.lim) : (v.ecnt == 8'd0);
        sb.push_back(e);
        @(posedge FPGA_clk);
        #1;
        g = sb.pop_front();
        if (g.sel) begin
            acnt = count_b; atick = tick_b; atc = tc_b; aovf = ovf_b; aat = at_b;
        end else begin
            acnt = count_a; atick = tick_a; atc = tc_a; aovf = ovf_a; aat = at_a;
        end
        tests_run++;
        if (acnt !== g.cnt || atick !== g.tick || atc !== g.tc || aovf !== g.ovf || aat !== g.at) begin
            tests_failed++;
            $display("FAIL %s%0d: got cnt=%0d tick=%b tc=%b ovf=%b at_term=%b, expected cnt=%0d tick=%b tc=%b ovf=%b at_term=%b",
                     g.sel ? "B" : "A", g.id, acnt, atick, atc, aovf, aat,
                     g.cnt, g.tick, g.tc, g.ovf, g.at);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit en;
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0; up_down = 1'b1;
        limit = 8'd5; sat_mode = 1'b0; enable = 1'b0;
        @(posedge FPGA_clk);
        #1;

        // ---------------- Instance A (PRESCALE=1) vector table ----------------
        //                  r  c  l  lv     ud lim    s  e   cnt    tk tc ov
        tbl.push_back(mk(1, 0, 0, 8'd0,   1, 8'd5,  0, 0,  8'd0,  0, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd1,  1, 0, 0)); // up wrap
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd2,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd3,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd4,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd5,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd0,  1, 1, 1)); // wrap
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd1,  1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd5,  0, 1,  8'd2,  1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 8'd5,  0, 1,  8'd0,  0, 0, 0)); // clear
        tbl.push_back(mk(0, 0, 1, 8'd3,   0, 8'd5,  1, 1,  8'd3,  0, 0, 0)); // load 3
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 1,  8'd2,  1, 0, 0)); // down sat
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 1,  8'd1,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 1,  8'd0,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 1,  8'd0,  1, 1, 1)); // blocked
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 1,  8'd0,  1, 1, 1)); // blocked
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd5,  1, 0,  8'd0,  0, 0, 1)); // hold
        tbl.push_back(mk(0, 0, 1, 8'd200, 1, 8'd10, 0, 1,  8'd200, 0, 0, 1)); // load > limit
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd10, 0, 1,  8'd0,  1, 1, 1)); // wraps to 0
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd10, 0, 1,  8'd1,  1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 8'd200, 1, 8'd10, 0, 1,  8'd0,  0, 0, 0)); // clear beats load
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd0,  0, 1,  8'd0,  1, 1, 1)); // limit=0
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd0,  0, 1,  8'd0,  1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd0,  1, 1,  8'd0,  1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd9,  0, 1,  8'd9,  1, 1, 1)); // down wrap to limit
        tbl.push_back(mk(0, 0, 0, 8'd0,   0, 8'd9,  0, 1,  8'd8,  1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd9,  1, 1,  8'd9,  1, 0, 1)); // up sat
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd9,  1, 1,  8'd9,  1, 1, 1)); // clamp
        tbl.push_back(mk(0, 0, 1, 8'd200, 1, 8'd9,  1, 1,  8'd200, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'd0,   1, 8'd9,  1, 1,  8'd9,  1, 1, 1)); // clamp to limit
        tbl.push_back(mk(0, 1, 0, 8'd0,   1, 8'd9,  1, 1,  8'd0,  0, 0, 0)); // clear + step
        foreach (tbl[i]) cyc(1'b0, i, tbl[i]);

        // ---------------- Instance B (PRESCALE=4): prescaler ----------------
        cyc(1'b1, 100, mk(1, 0, 0, 8'd0, 1, 8'd255, 0, 0, 8'd0, 0, 0, 0));
        k = 0;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            if (en) k++;
            cyc(1'b1, 101 + i, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, en,
                                  8'(k / 4), en && (k % 4 == 0), 0, 0));
        end

        // ---------------- Instance B: reset mid-count ----------------
        cyc(1'b1, 200, mk(0, 0, 1, 8'd255, 1, 8'd255, 0, 1, 8'd255, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 201 + i, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd255, 0, 0, 0));
        cyc(1'b1, 204, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd0, 1, 1, 1));
        cyc(1'b1, 205, mk(0, 0, 1, 8'd6, 1, 8'd255, 0, 1, 8'd6, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 206 + i, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd6, 0, 0, 1));
        cyc(1'b1, 209, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd7, 1, 0, 1));
        cyc(1'b1, 210, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd7, 0, 0, 1));
        cyc(1'b1, 211, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd7, 0, 0, 1));
        cyc(1'b1, 212, mk(1, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd0, 0, 0, 0)); // rst wins
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 213 + i, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd0, 0, 0, 0));
        cyc(1'b1, 216, mk(0, 0, 0, 8'd0, 1, 8'd255, 0, 1, 8'd1, 1, 0, 0));

        // Every queued expectation must have been consumed.
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
